ahb_decode_mux: RTL and testbench



---
 rtl/param_pkg.sv | 13 +
 rtl/ahb_default_sub.sv | 34 +++
 rtl/ahb_decode_mux.sv | 65 ++++++
 tb/tb_ahb_decode_mux.sv | 101 ++++++++++
 4 files changed

// File: rtl/param_pkg.sv
// param_pkg: shared widths, default address map and encodings for the AHB decoder/mux.
package param_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_SUBORD = 4;
  // 0x3000_0000..0x3FFF_FFFF and everything from 0x5000_0000 up are unmapped
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR [NUM_SUBORD] =
    '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000};
  localparam logic [ADDR_WIDTH-1:0] HIGH_ADDR [NUM_SUBORD] =
    '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h5000_0000};
  typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} htrans_e;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;
endpackage

// File: rtl/ahb_default_sub.sv
// ahb_default_sub: two-cycle ERROR responder for transfers that hit no mapped region.
module ahb_default_sub
  import param_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_ready,
  input  logic i_req,
  output logic o_ready,
  output logic o_resp
);
  ds_state_e r_state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DS_IDLE;
      o_ready <= 1'b1;
      o_resp  <= 1'b0;
    end else begin
      case (r_state)
        DS_ERR1: begin
          r_state <= DS_ERR2;
          o_ready <= 1'b1;
          o_resp  <= 1'b1;
        end
        default: begin
          // ERR2 chains straight into ERR1 when the next transfer is also unmapped
          r_state <= (i_ready && i_req) ? DS_ERR1 : DS_IDLE;
          o_ready <= !(i_ready && i_req);
          o_resp  <= i_ready && i_req;
        end
      endcase
    end
  end
endmodule

// File: rtl/ahb_decode_mux.sv
// ahb_decode_mux: AHB address decoder with data-phase response mux and default subordinate.
module ahb_decode_mux #(
  parameter int ADDR_WIDTH = param_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = param_pkg::DATA_WIDTH,
  parameter int NUM_SUBORD = param_pkg::NUM_SUBORD,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR [NUM_SUBORD] = param_pkg::BASE_ADDR,
  parameter logic [ADDR_WIDTH-1:0] HIGH_ADDR [NUM_SUBORD] = param_pkg::HIGH_ADDR
) (
  input  logic                                 Hclk,
  input  logic                                 Hrst,
  input  logic [ADDR_WIDTH-1:0]                Haddr,
  input  logic [1:0]                           Htrans,
  input  logic [NUM_SUBORD-1:0][DATA_WIDTH-1:0] Hrdata_s,
  input  logic [NUM_SUBORD-1:0]                Hreadyout_s,
  input  logic [NUM_SUBORD-1:0]                Hresp_s,
  output logic [NUM_SUBORD-1:0]                Hsel,
  output logic [DATA_WIDTH-1:0]                Hrdata,
  output logic                                 Hready,
  output logic                                 Hresp
);
  import param_pkg::*;
  logic [NUM_SUBORD:0] r_dsel;
  logic                w_unmapped;
  logic                w_req;
  logic                w_ds_ready;
  logic                w_ds_resp;
  // scan high to low so the lowest matching index wins on overlap
  always_comb begin
    Hsel = '0;
    for (int i = NUM_SUBORD - 1; i >= 0; i--)
      if (Haddr >= BASE_ADDR[i] && Haddr < HIGH_ADDR[i]) begin
        Hsel    = '0;
        Hsel[i] = 1'b1;
      end
  end
  assign w_unmapped = ~|Hsel;
  assign w_req      = w_unmapped && (htrans_e'(Htrans) inside {HT_NONSEQ, HT_SEQ});
  always_ff @(posedge Hclk or posedge Hrst) begin
    if (Hrst) r_dsel <= '0;
    else if (Hready) r_dsel <= {w_unmapped, Hsel};
  end
  always_comb begin
    Hrdata = '0;
    Hready = 1'b1;
    Hresp  = 1'b0;
    for (int i = 0; i < NUM_SUBORD; i++)
      if (r_dsel[i]) begin
        Hrdata = Hrdata_s[i];
        Hready = Hreadyout_s[i];
        Hresp  = Hresp_s[i];
      end
    if (r_dsel[NUM_SUBORD]) begin
      Hready = w_ds_ready;
      Hresp  = w_ds_resp;
    end
  end
  ahb_default_sub u_default_sub (
    .clk     (Hclk),
    .rst     (Hrst),
    .i_ready (Hready),
    .i_req   (w_req),
    .o_ready (w_ds_ready),
    .o_resp  (w_ds_resp)
  );
endmodule

// File: tb/tb_ahb_decode_mux.sv
// tb_ahb_decode_mux: directed vectors pushed to a scoreboard queue, checked by a separate monitor.
module tb_ahb_decode_mux;
  logic              Hclk = 1'b0;
  logic              Hrst = 1'b1;
  logic [31:0]       Haddr = '0;
  logic [1:0]        Htrans = 2'd0;
  logic [3:0][31:0]  Hrdata_s;
  logic [3:0]        Hreadyout_s = 4'hF;
  logic [3:0]        Hresp_s = 4'h0;
  logic [3:0]        Hsel;
  logic [31:0]       Hrdata;
  logic              Hready;
  logic              Hresp;

  typedef struct {
    string       nm;
    logic [3:0]  hsel;
    logic        rdy;
    logic        rsp;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;

  localparam logic [31:0] R0 = 32'h0000_0000, R1 = 32'h1000_0000, R2 = 32'h2000_0000;
  localparam logic [31:0] R3 = 32'h4000_0000, UN = 32'h5000_0000, UG = 32'h3000_0000;
  localparam logic [1:0] ID = 2'd0, BY = 2'd1, NS = 2'd2, SQ = 2'd3;

  ahb_decode_mux dut (
    .Hclk(Hclk), .Hrst(Hrst), .Haddr(Haddr), .Htrans(Htrans),
    .Hrdata_s(Hrdata_s), .Hreadyout_s(Hreadyout_s), .Hresp_s(Hresp_s),
    .Hsel(Hsel), .Hrdata(Hrdata), .Hready(Hready), .Hresp(Hresp)
  );

  always #5 Hclk = ~Hclk;

  assign Hrdata_s = {32'h4444_4444, 32'hA5A5A5A5, 32'h2222_2222, 32'h1111_1111};

  task automatic step(input string nm, input logic [31:0] a, input logic [1:0] t,
                      input logic [3:0] rdy, input logic [3:0] rs_s, input logic rs,
                      input logic [3:0] eh, input logic er, input logic ep, input logic [31:0] ed);
    exp_t e;
    @(posedge Hclk);
    #1;
    Haddr = a; Htrans = t; Hreadyout_s = rdy; Hresp_s = rs_s; Hrst = rs;
    e.nm = nm; e.hsel = eh; e.rdy = er; e.rsp = ep; e.d = ed;
    q.push_back(e);
  endtask

  always @(negedge Hclk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (Hsel !== e.hsel || Hready !== e.rdy || Hresp !== e.rsp || Hrdata !== e.d) begin
        bad++;
        $display("FAIL %s: got hsel=%b rdy=%b rsp=%b d=%h, want hsel=%b rdy=%b rsp=%b d=%h",
                 e.nm, Hsel, Hready, Hresp, Hrdata, e.hsel, e.rdy, e.rsp, e.d);
      end
    end
  end

  initial begin
    step("reset",       R0, ID, 4'hF, 4'h0, 1, 4'b0001, 1, 0, 32'h0);
    step("s2_addr",     R2, NS, 4'hF, 4'h0, 0, 4'b0100, 1, 0, 32'h0);
    step("s2_data",     R0, ID, 4'hF, 4'h0, 0, 4'b0001, 1, 0, 32'hA5A5A5A5);
    step("unm_addr",    UN, NS, 4'hF, 4'h0, 0, 4'b0000, 1, 0, 32'h1111_1111);
    step("err1",        UG, ID, 4'hF, 4'h0, 0, 4'b0000, 0, 1, 32'h0);
    step("err2",        R1, ID, 4'hF, 4'h0, 0, 4'b0010, 1, 1, 32'h0);
    step("s1_ok",       UN, NS, 4'hF, 4'h0, 0, 4'b0000, 1, 0, 32'h2222_2222);
    step("b2b_err1a",   UN, NS, 4'hF, 4'h0, 0, 4'b0000, 0, 1, 32'h0);
    step("b2b_err2a",   UN, SQ, 4'hF, 4'h0, 0, 4'b0000, 1, 1, 32'h0);
    step("b2b_err1b",   R0, ID, 4'hF, 4'h0, 0, 4'b0001, 0, 1, 32'h0);
    step("b2b_err2b",   R1, NS, 4'hF, 4'h0, 0, 4'b0010, 1, 1, 32'h0);
    step("wait1",       R3, NS, 4'hD, 4'h0, 0, 4'b1000, 0, 0, 32'h2222_2222);
    step("wait2",       R3, NS, 4'hD, 4'h0, 0, 4'b1000, 0, 0, 32'h2222_2222);
    step("wait3",       R3, NS, 4'hD, 4'h0, 0, 4'b1000, 0, 0, 32'h2222_2222);
    step("s1_done",     R3, NS, 4'hF, 4'h0, 0, 4'b1000, 1, 0, 32'h2222_2222);
    step("s3_data",     UN, ID, 4'hF, 4'h0, 0, 4'b0000, 1, 0, 32'h4444_4444);
    step("unm_idle",    UN, BY, 4'hF, 4'h0, 0, 4'b0000, 1, 0, 32'h0);
    step("unm_busy",    R0, ID, 4'hF, 4'h0, 0, 4'b0001, 1, 0, 32'h0);
    step("pre_err",     UN, NS, 4'hF, 4'h0, 0, 4'b0000, 1, 0, 32'h1111_1111);
    step("err1_pre_rst",UN, NS, 4'hF, 4'h0, 0, 4'b0000, 0, 1, 32'h0);
    @(negedge Hclk);
    #2 Hrst = 1'b1;
    step("in_rst",      UN, NS, 4'hF, 4'h0, 1, 4'b0000, 1, 0, 32'h0);
    step("rel1",        UN, ID, 4'hF, 4'h0, 0, 4'b0000, 1, 0, 32'h0);
    step("rel2",        R0, ID, 4'hF, 4'h0, 0, 4'b0001, 1, 0, 32'h0);
    step("top_s3",      32'h4FFF_FFFF, NS, 4'hF, 4'h0, 0, 4'b1000, 1, 0, 32'h1111_1111);
    step("s3_resp_err", 32'h0FFF_FFFF, ID, 4'hF, 4'h8, 0, 4'b0001, 1, 1, 32'h4444_4444);
    step("s0_back",     R0, ID, 4'hF, 4'h0, 0, 4'b0001, 1, 0, 32'h1111_1111);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Hclk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
